// File: rtl/ipif_reg_slave_if.sv
// IPIF register-slave bus bundle.
//   Bus2IP_CS    : chip select for the slave
//   Bus2IP_RNW   : 1 = read, 0 = write (informational; the CE bits decide the access)
//   Bus2IP_BE    : write byte enables, one per data byte
//   Bus2IP_RdCE  : per-register read chip enables (bit i = register i)
//   Bus2IP_WrCE  : per-register write chip enables (bit i = register i)
//   Bus2IP_Data  : write data
//   IP2Bus_Data  : read data, non-zero only during a good read ack
//   IP2Bus_WrAck : single-cycle write acknowledge
//   IP2Bus_RdAck : single-cycle read acknowledge
//   IP2Bus_Error : error flag, only ever high alongside an ack
interface ipif_reg_slave_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned N_REG = 8
);
  logic              Bus2IP_CS;
  logic              Bus2IP_RNW;
  logic [DW/8-1:0]   Bus2IP_BE;
  logic [N_REG-1:0]  Bus2IP_RdCE;
  logic [N_REG-1:0]  Bus2IP_WrCE;
  logic [DW-1:0]     Bus2IP_Data;
  logic [DW-1:0]     IP2Bus_Data;
  logic              IP2Bus_WrAck;
  logic              IP2Bus_RdAck;
  logic              IP2Bus_Error;

  modport master (
    output Bus2IP_CS, Bus2IP_RNW, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE, Bus2IP_Data,
    input  IP2Bus_Data, IP2Bus_WrAck, IP2Bus_RdAck, IP2Bus_Error
  );

  // RNW carries no information the CE bits do not already give, so the slave
  // view leaves it out.
  modport slave (
    input  Bus2IP_CS, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE, Bus2IP_Data,
    output IP2Bus_Data, IP2Bus_WrAck, IP2Bus_RdAck, IP2Bus_Error
  );
endinterface

// File: rtl/ipif_reg_slave.sv
// IPIF register slave: N_REG registers of C_S_AXI_DATA_WIDTH bits, selected by
// one-hot CE bits, acked in the cycle after the request edge with no wait states.
//   Bus2IP_Clk    : clock, rising edge
//   Bus2IP_Reset  : synchronous active-high reset
//   bus           : IPIF slave port (see ipif_reg_slave_if)
//   reg_out       : register contents, register i at [i*DW +: DW]
//   reg_wr_strobe : one-cycle pulse per accepted write to register i
//   status_in     : read values for read-only registers, slice i at [i*DW +: DW]
// RO_MASK bits mark read-only registers (reads return status_in, writes error).
// PULSE_MASK bits mark self-clearing registers (visible one cycle, read as 0).
module ipif_reg_slave #(
  parameter int unsigned      C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned      N_REG              = 8,
  parameter logic [N_REG-1:0] RO_MASK            = '0,
  parameter logic [N_REG-1:0] PULSE_MASK         = '0
) (
  input  logic                                  Bus2IP_Clk,
  input  logic                                  Bus2IP_Reset,
  ipif_reg_slave_if.slave                       bus,
  output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
  output logic [N_REG-1:0]                      reg_wr_strobe,
  input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   status_in
);
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NB = DW / 8;
  localparam int unsigned IW = (N_REG > 1) ? $clog2(N_REG) : 1;

  logic [DW-1:0]    regs [N_REG];
  logic             armed;

  logic             rd_any, wr_any, rd_one, wr_one;
  logic             req, wr_ok, rd_ok;
  logic [N_REG-1:0] sel;
  logic [IW-1:0]    idx;
  logic [DW-1:0]    rd_data;

  always_comb begin
    rd_any = |bus.Bus2IP_RdCE;
    wr_any = |bus.Bus2IP_WrCE;
    rd_one = ((bus.Bus2IP_RdCE & (bus.Bus2IP_RdCE - 1'b1)) == '0);
    wr_one = ((bus.Bus2IP_WrCE & (bus.Bus2IP_WrCE - 1'b1)) == '0);
    req    = bus.Bus2IP_CS && (rd_any || wr_any) && armed;
    wr_ok  = req && wr_any && wr_one && !rd_any;
    rd_ok  = req && rd_any && rd_one && !wr_any;

    sel = rd_any ? bus.Bus2IP_RdCE : bus.Bus2IP_WrCE;
    idx = '0;
    for (int unsigned i = 0; i < N_REG; i++) begin
      if (sel[i]) idx = IW'(i);
    end

    if (RO_MASK[idx])         rd_data = status_in[idx*DW +: DW];
    else if (PULSE_MASK[idx]) rd_data = '0;
    else                      rd_data = regs[idx];
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < N_REG; i++) begin
      reg_out[i*DW +: DW] = regs[i];
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      for (int unsigned i = 0; i < N_REG; i++) regs[i] <= '0;
      reg_wr_strobe    <= '0;
      bus.IP2Bus_WrAck <= 1'b0;
      bus.IP2Bus_RdAck <= 1'b0;
      bus.IP2Bus_Error <= 1'b0;
      bus.IP2Bus_Data  <= '0;
      armed            <= 1'b1;
    end else begin
      reg_wr_strobe    <= '0;
      bus.IP2Bus_WrAck <= 1'b0;
      bus.IP2Bus_RdAck <= 1'b0;
      bus.IP2Bus_Error <= 1'b0;
      bus.IP2Bus_Data  <= '0;

      // Pulse registers clear every cycle; a write below overrides the clear.
      for (int unsigned i = 0; i < N_REG; i++) begin
        if (PULSE_MASK[i]) regs[i] <= '0;
      end

      if (req) begin
        // One ack per request: disarm until CS or the CEs drop.
        armed <= 1'b0;
        if (wr_ok) begin
          bus.IP2Bus_WrAck <= 1'b1;
          if (RO_MASK[idx]) begin
            bus.IP2Bus_Error <= 1'b1;
          end else begin
            reg_wr_strobe[idx] <= 1'b1;
            for (int unsigned b = 0; b < NB; b++) begin
              if (bus.Bus2IP_BE[b]) regs[idx][b*8 +: 8] <= bus.Bus2IP_Data[b*8 +: 8];
            end
          end
        end else if (rd_ok) begin
          bus.IP2Bus_RdAck <= 1'b1;
          bus.IP2Bus_Data  <= rd_data;
        end else begin
          bus.IP2Bus_Error <= 1'b1;
          if (rd_any) bus.IP2Bus_RdAck <= 1'b1;
          else        bus.IP2Bus_WrAck <= 1'b1;
        end
      end else if (!bus.Bus2IP_CS || !(rd_any || wr_any)) begin
        armed <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ipif_reg_slave.sv
// Directed bench for ipif_reg_slave with reg 3 read-only and reg 4 self-clearing.
module tb_ipif_reg_slave;
  localparam int unsigned DW    = 32;
  localparam int unsigned N_REG = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REG*DW-1:0]   reg_out;
  logic [N_REG-1:0]      reg_wr_strobe;
  logic [N_REG*DW-1:0]   status_in;

  int checks = 0;
  int errors = 0;
  int wr_acks, strobes;

  ipif_reg_slave_if #(.DW(DW), .N_REG(N_REG)) ifc ();

  ipif_reg_slave #(
    .C_S_AXI_DATA_WIDTH (DW),
    .N_REG              (N_REG),
    .RO_MASK            (8'h08),
    .PULSE_MASK         (8'h10)
  ) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Reset  (rst),
    .bus           (ifc),
    .reg_out       (reg_out),
    .reg_wr_strobe (reg_wr_strobe),
    .status_in     (status_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rslice(input int unsigned i);
    return reg_out[i*DW +: DW];
  endfunction

  task automatic idle();
    ifc.Bus2IP_CS   = 1'b0;
    ifc.Bus2IP_RdCE = '0;
    ifc.Bus2IP_WrCE = '0;
  endtask

  task automatic set_wr(input int unsigned r, input logic [31:0] d, input logic [3:0] be);
    ifc.Bus2IP_CS   = 1'b1;
    ifc.Bus2IP_RNW  = 1'b0;
    ifc.Bus2IP_WrCE = N_REG'(1) << r;
    ifc.Bus2IP_RdCE = '0;
    ifc.Bus2IP_Data = d;
    ifc.Bus2IP_BE   = be;
  endtask

  task automatic set_rd(input int unsigned r);
    ifc.Bus2IP_CS   = 1'b1;
    ifc.Bus2IP_RNW  = 1'b1;
    ifc.Bus2IP_RdCE = N_REG'(1) << r;
    ifc.Bus2IP_WrCE = '0;
  endtask

  initial begin
    rst = 1'b1;
    status_in = '0;
    status_in[3*DW +: DW] = 32'hDEAD_BEEF;
    ifc.Bus2IP_RNW  = 1'b0;
    ifc.Bus2IP_BE   = '0;
    ifc.Bus2IP_Data = '0;
    idle();
    tick(); tick();
    chk("rst_reg_out", reg_out, '0);
    chk("rst_acks", {ifc.IP2Bus_WrAck, ifc.IP2Bus_RdAck, ifc.IP2Bus_Error}, 3'b000);
    chk("rst_data", ifc.IP2Bus_Data, 0);
    chk("rst_strobe", reg_wr_strobe, 0);
    rst = 1'b0;
    tick();

    // Basic write then read of reg 2
    set_wr(2, 32'hA5A5_1234, 4'hF); tick();
    chk("wr2_acks", {ifc.IP2Bus_WrAck, ifc.IP2Bus_RdAck, ifc.IP2Bus_Error}, 3'b100);
    chk("wr2_strobe", reg_wr_strobe, 8'h04);
    chk("wr2_reg", rslice(2), 32'hA5A5_1234);
    idle(); tick();
    chk("wr2_ack_one_cycle", ifc.IP2Bus_WrAck, 1'b0);
    chk("wr2_strobe_one_cycle", reg_wr_strobe, 8'h00);
    set_rd(2); tick();
    chk("rd2_acks", {ifc.IP2Bus_WrAck, ifc.IP2Bus_RdAck, ifc.IP2Bus_Error}, 3'b010);
    chk("rd2_data", ifc.IP2Bus_Data, 32'hA5A5_1234);
    idle(); tick();
    chk("rd2_ack_one_cycle", ifc.IP2Bus_RdAck, 1'b0);
    chk("rd2_data_zero_after", ifc.IP2Bus_Data, 0);

    // Partial byte enables on reg 1
    set_wr(1, 32'h1122_3344, 4'hF); tick(); idle(); tick();
    set_wr(1, 32'hFFFF_FFFF, 4'h5); tick(); idle(); tick();
    chk("be5_reg1", rslice(1), 32'h11FF_33FF);
    chk("be5_reg2_untouched", rslice(2), 32'hA5A5_1234);

    // Read-only reg 3
    set_wr(3, 32'h1234_5678, 4'hF); tick();
    chk("ro_wr_acks", {ifc.IP2Bus_WrAck, ifc.IP2Bus_RdAck, ifc.IP2Bus_Error}, 3'b101);
    chk("ro_wr_strobe", reg_wr_strobe, 8'h00);
    chk("ro_wr_reg", rslice(3), 0);
    idle(); tick();
    chk("ro_err_cleared", ifc.IP2Bus_Error, 1'b0);
    set_rd(3); tick();
    chk("ro_rd_acks", {ifc.IP2Bus_WrAck, ifc.IP2Bus_RdAck, ifc.IP2Bus_Error}, 3'b010);
    chk("ro_rd_data", ifc.IP2Bus_Data, 32'hDEAD_BEEF);
    idle(); tick();

    // Pulse reg 4
    set_wr(4, 32'h0000_0007, 4'hF); tick();
    chk("pulse_reg_k", rslice(4), 32'h7);
    chk("pulse_strobe", reg_wr_strobe, 8'h10);
    idle(); tick();
    chk("pulse_reg_k1", rslice(4), 0);
    set_rd(4); tick();
    chk("pulse_rd_acks", {ifc.IP2Bus_RdAck, ifc.IP2Bus_Error}, 2'b10);
    chk("pulse_rd_data", ifc.IP2Bus_Data, 0);
    idle(); tick();

    // Held CE on reg 0, BE=0 still strobes
    set_wr(0, 32'h0000_0055, 4'h1);
    wr_acks = 0; strobes = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      wr_acks += int'(ifc.IP2Bus_WrAck);
      strobes += int'(reg_wr_strobe[0]);
    end
    chk("held_wr_acks", wr_acks, 1);
    chk("held_strobes", strobes, 1);
    chk("held_reg0", rslice(0), 32'h55);
    ifc.Bus2IP_CS = 1'b0; tick();
    wr_acks += int'(ifc.IP2Bus_WrAck);
    ifc.Bus2IP_CS = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      wr_acks += int'(ifc.IP2Bus_WrAck);
    end
    chk("held_rearm_acks", wr_acks, 2);
    idle(); tick();
    set_wr(0, 32'h0000_0000, 4'h0); tick();
    chk("be0_strobe", reg_wr_strobe, 8'h01);
    chk("be0_reg0", rslice(0), 32'h55);
    idle(); tick();

    // Erroneous requests
    ifc.Bus2IP_CS = 1'b1; ifc.Bus2IP_RdCE = 8'b0000_0011; tick();
    chk("multi_rd_acks", {ifc.IP2Bus_WrAck, ifc.IP2Bus_RdAck, ifc.IP2Bus_Error}, 3'b011);
    chk("multi_rd_data", ifc.IP2Bus_Data, 0);
    idle(); tick();
    ifc.Bus2IP_CS = 1'b1; ifc.Bus2IP_Data = 32'hFFFF_FFFF; ifc.Bus2IP_BE = 4'hF;
    ifc.Bus2IP_WrCE = 8'b0000_0001; ifc.Bus2IP_RdCE = 8'b0000_0010; tick();
    chk("mixed_acks", {ifc.IP2Bus_WrAck, ifc.IP2Bus_RdAck, ifc.IP2Bus_Error}, 3'b011);
    chk("mixed_data", ifc.IP2Bus_Data, 0);
    chk("mixed_strobe", reg_wr_strobe, 8'h00);
    chk("mixed_reg0", rslice(0), 32'h55);
    idle(); tick();
    ifc.Bus2IP_CS = 1'b0; ifc.Bus2IP_WrCE = 8'b0000_0001; tick(); tick();
    chk("cs0_acks", {ifc.IP2Bus_WrAck, ifc.IP2Bus_RdAck, ifc.IP2Bus_Error}, 3'b000);
    chk("cs0_reg0", rslice(0), 32'h55);
    idle(); tick();

    // Reset in the same cycle as a write, request held across release
    set_wr(5, 32'h0000_CAFE, 4'hF);
    rst = 1'b1; tick();
    chk("rstmid_acks", {ifc.IP2Bus_WrAck, ifc.IP2Bus_RdAck}, 2'b00);
    chk("rstmid_reg5", rslice(5), 0);
    chk("rstmid_reg0_cleared", rslice(0), 0);
    rst = 1'b0; tick();
    chk("rstrel_ack", ifc.IP2Bus_WrAck, 1'b1);
    chk("rstrel_reg5", rslice(5), 32'h0000_CAFE);
    idle(); tick();
    chk("final_idle_acks", {ifc.IP2Bus_WrAck, ifc.IP2Bus_RdAck, ifc.IP2Bus_Error}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ipif_reg_slave.md
IPIF_REG_SLAVE -- requirements
Module: ipif_reg_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, meaning the data bus width; legal values are 32 and 64.
REQ-002 SHALL have parameter N_REG, default 8, meaning the number of registers, one CE bit each; legal range is 1-64.
REQ-003 SHALL have parameter RO_MASK [N_REG-1:0], default '0; a set bit makes that register read-only, sourced from status_in.
REQ-004 SHALL have parameter PULSE_MASK [N_REG-1:0], default '0; a set bit makes that register self-clearing after one cycle.
REQ-005 Bus2IP_Clk  input  1  is the single clock; all logic SHALL be on its rising edge.
REQ-006 Bus2IP_Reset  input  1  is a synchronous, active-high reset.
REQ-007 Bus2IP_CS  input  1  is the chip select for this block.
REQ-008 Bus2IP_RNW  input  1  is 1 for read, 0 for write; it is informational only, and the CE bits decide the access type.
REQ-009 Bus2IP_BE  input  DW/8  gives the write byte enables.
REQ-010 Bus2IP_RdCE / Bus2IP_WrCE  input  N_REG each; bit i selects register i (little-endian, bit 0 = register 0).
REQ-011 Bus2IP_Data  input  DW  carries the write data.
REQ-012 IP2Bus_Data  output  DW  carries the read data.
REQ-013 IP2Bus_WrAck / IP2Bus_RdAck / IP2Bus_Error  output  1 each  are the transaction responses.
REQ-014 reg_out  output  N_REG*DW  gives the register contents; register i occupies slice [i*DW +: DW].
REQ-015 reg_wr_strobe  output  N_REG  pulses for one cycle on an accepted write to register i.
REQ-016 status_in  input  N_REG*DW  supplies the read values for RO registers.

Function
REQ-017 A request SHALL be sampled at rising edge k when all of the following hold: CS=1, any RdCE or WrCE bit is set, and the internal armed flag is 1.
REQ-018 For a request sampled at edge k, exactly one of WrAck or RdAck SHALL be high for the single cycle k..k+1; the block adds no wait states and produces no second ack.
REQ-019 After the ack, armed SHALL be 0 until a cycle samples CS=0 or all CE bits 0; armed returns to 1 at that edge.
REQ-020 Write path: when exactly one WrCE bit i is set and no RdCE bit is set, each byte b with BE[b]=1 of register i SHALL be updated at edge k; bytes with BE[b]=0 are unchanged.
REQ-021 On an accepted write, reg_wr_strobe[i] SHALL be high in the same cycle as WrAck, and SHALL pulse even when BE=0.
REQ-022 A PULSE_MASK register SHALL show the written value on reg_out for exactly cycle k..k+1 and then return to 0.
REQ-023 A write to an RO_MASK register SHALL change no state, SHALL produce no strobe, and SHALL return WrAck=1 with Error=1.
REQ-024 Read path: when exactly one RdCE bit i is set and no WrCE bit is set, IP2Bus_Data SHALL be registered at edge k and valid during the RdAck cycle.
REQ-025 The read value SHALL be status_in slice i sampled at edge k for RO registers, and the current register value otherwise.
REQ-026 A PULSE_MASK register SHALL read back as 0.
REQ-027 A request with more than one CE bit set, or with RdCE and WrCE both nonzero, SHALL cause no state change and no strobe.
REQ-028 Such an erroneous request SHALL assert Error=1 with RdAck if any RdCE bit is set, otherwise with WrAck.
REQ-029 IP2Bus_Error SHALL be high only in a cycle where an ack is high.
REQ-030 IP2Bus_Data SHALL be 0 in every cycle where RdAck is 0, and SHALL be 0 on an erroneous read.
REQ-031 A CE bit set while CS=0 SHALL be ignored.
REQ-032 A CE set while armed=0 SHALL be ignored; this includes a held CE.

Reset
REQ-033 While Bus2IP_Reset=1 at an edge, the following SHALL be cleared: all registers, reg_out, reg_wr_strobe, all acks, Error, and IP2Bus_Data; armed SHALL be set to 1.
REQ-034 Reset SHALL take priority over a request sampled at the same edge; that request is dropped with no ack.
REQ-035 If CS and CE are still held at the first edge after reset deasserts, the block SHALL treat them as a new request.

Verification
REQ-036 Scenario, basic write then read: reset; write 0xA5A5_1234 to reg 2 with BE=0xF; read reg 2. Required: WrAck one cycle; reg_wr_strobe[2] one cycle; reg_out[2]=0xA5A5_1234; RdAck one cycle with Data=0xA5A5_1234 and Error=0.
REQ-037 Scenario, partial byte enable: reg 1 holds 0x1122_3344; write 0xFFFF_FFFF with BE=0x5. Required: reg 1 = 0x11FF_33FF.
REQ-038 Scenario, RO and pulse registers: RO_MASK=0x08, PULSE_MASK=0x10, status_in[3]=0xDEAD_BEEF. Required:
- Write to reg 3 gives WrAck=1, Error=1, and no strobe.
- Read of reg 3 returns 0xDEAD_BEEF.
- Write 0x7 to reg 4 shows 0x7 on reg_out for exactly one cycle.
- Read of reg 4 returns 0.
REQ-039 Scenario, held CE: hold WrCE[0] and CS for 10 cycles. Required: exactly one WrAck and one strobe; after CS drops for one cycle and rises again, exactly one further ack.
REQ-040 Scenario, erroneous and out-of-window requests:
- RdCE=0b0011 gives RdAck=1, Error=1, Data=0.
- WrCE=0b0001 together with RdCE=0b0010 gives WrAck=0, RdAck=1, Error=1, and no register change.
- CE set with CS=0 gives no ack.
REQ-041 Scenario, reset mid-operation: assert reset in the same cycle a write is sampled. Required: no ack, register stays 0; the request held after reset release is acked one cycle later.
